hazard_ctrl: RTL and testbench

//  Pipeline controller for the 5-stage RV32I core: drives stall/flush of the IF/ID and
//  ID/EX pipeline registers and the EX forwarding selects. Sequences instruction-memory

---
 rtl/hazard_ctrl.sv | 119 +++++++++++
 tb/tb_hazard_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - RV32I 5-stage pipeline hazard controller
// Stall/flush/forwarding control, imem wait/redirect FSM, saturating perf counters.
module hazard_ctrl #(
  parameter int REG_W    = 5,
  parameter int CNT_W    = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] rs1_d,
  input  logic [REG_W-1:0] rs2_d,
  input  logic [REG_W-1:0] rs1_e,
  input  logic [REG_W-1:0] rs2_e,
  input  logic [REG_W-1:0] rd_e,
  input  logic [REG_W-1:0] rd_m,
  input  logic [REG_W-1:0] rd_w,
  input  logic             ld_e,
  input  logic             rw_m,
  input  logic             rw_w,
  input  logic             pc_src_e,
  input  logic             imem_ready,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_d,
  output logic             flush_e,
  output logic [1:0]       fwd_a_e,
  output logic [1:0]       fwd_b_e,
  output logic             imem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    IWAIT = 2'd1,
    REDIR = 2'd2
  } state_t;

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  state_t         state, state_nxt;
  logic [WW-1:0]  wait_cnt;
  logic           lu;

  assign lu = ld_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));

  // MEM result is younger than WB, so it wins when both match.
  always_comb begin
    fwd_a_e = 2'b00;
    fwd_b_e = 2'b00;
    if (rst_n) begin
      if (rw_m && rd_m != '0 && rd_m == rs1_e)      fwd_a_e = 2'b10;
      else if (rw_w && rd_w != '0 && rd_w == rs1_e) fwd_a_e = 2'b01;
      if (rw_m && rd_m != '0 && rd_m == rs2_e)      fwd_b_e = 2'b10;
      else if (rw_w && rd_w != '0 && rd_w == rs2_e) fwd_b_e = 2'b01;
    end
  end

  always_comb begin
    state_nxt = state;
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    if (imem_ready)    state_nxt = RUN;
    else if (pc_src_e) state_nxt = REDIR;
    else if (state == RUN) state_nxt = IWAIT;

    if (!rst_n) begin
      state_nxt = RUN;
    end else if (pc_src_e) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (state == REDIR || !imem_ready) begin
      // Keep a load-use stall intact; otherwise feed a bubble into decode.
      stall_f = 1'b1;
      if (lu) begin
        stall_d = 1'b1;
        flush_e = 1'b1;
      end else begin
        flush_d = 1'b1;
      end
    end else if (lu) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  // The cycle that leaves RUN on a not-ready fetch counts as the first wait cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt     <= '0;
      imem_timeout <= 1'b0;
    end else if (imem_ready) begin
      wait_cnt <= '0;
    end else begin
      if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 1'b1;
      if (wait_cnt >= WAIT_MAX - 1'b1) imem_timeout <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_f && stall_cnt != '1)               stall_cnt <= stall_cnt + 1'b1;
      if ((flush_d || flush_e) && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - randomized self-checking bench for hazard_ctrl
module tb_hazard_ctrl;
  localparam int CW = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] rs1_d = '0, rs2_d = '0, rs1_e = '0, rs2_e = '0, rd_e = '0, rd_m = '0, rd_w = '0;
  logic ld_e = 1'b0, rw_m = 1'b0, rw_w = 1'b0, pc_src_e = 1'b0, imem_ready = 1'b1;
  logic stall_f, stall_d, flush_d, flush_e, imem_timeout;
  logic [1:0] fwd_a_e, fwd_b_e;
  logic [CW-1:0] stall_cnt, flush_cnt;

  hazard_ctrl #(.REG_W(5), .CNT_W(CW), .MAX_WAIT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
    .ld_e(ld_e), .rw_m(rw_m), .rw_w(rw_w),
    .pc_src_e(pc_src_e), .imem_ready(imem_ready),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .imem_timeout(imem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: is the outstanding fetch wrong-path, how long have we waited, counters.
  bit m_discard;
  int m_wait, m_sc, m_fc;
  bit m_to;
  int cmax = (1 << CW) - 1;

  function automatic int fwd_ref(input int rs);
    if (rw_m && rd_m != 0 && rd_m == rs) return 2;
    if (rw_w && rd_w != 0 && rd_w == rs) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    m_discard = 0; m_wait = 0; m_to = 0; m_sc = 0; m_fc = 0;
  endtask

  // Inputs are set at a negedge; check, then advance the model across the posedge.
  task automatic step();
    bit lu, sf, sd, fd, fe;
    #1;
    lu = ld_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
    sf = 0; sd = 0; fd = 0; fe = 0;
    if (pc_src_e) begin fd = 1; fe = 1; end
    else if (m_discard || !imem_ready) begin
      sf = 1;
      if (lu) begin sd = 1; fe = 1; end else fd = 1;
    end else if (lu) begin sf = 1; sd = 1; fe = 1; end
    check("stall_f", stall_f, sf);
    check("stall_d", stall_d, sd);
    check("flush_d", flush_d, fd);
    check("flush_e", flush_e, fe);
    check("fwd_a", fwd_a_e, fwd_ref(rs1_e));
    check("fwd_b", fwd_b_e, fwd_ref(rs2_e));
    check("timeout", imem_timeout, m_to);
    check("stall_cnt", stall_cnt, m_sc);
    check("flush_cnt", flush_cnt, m_fc);
    @(posedge clk);
    if (sf && m_sc < cmax) m_sc++;
    if ((fd || fe) && m_fc < cmax) m_fc++;
    if (imem_ready) begin m_discard = 0; m_wait = 0; end
    else begin
      m_discard = m_discard | pc_src_e;
      m_wait++;
      if (m_wait >= 15) m_to = 1;
    end
    @(negedge clk);
  endtask

  task automatic quiet();
    {rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
    {ld_e, rw_m, rw_w, pc_src_e} = '0;
    imem_ready = 1'b1;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    pc_src_e = 1'b1; ld_e = 1'b1; rd_e = 5'd3; rs1_d = 5'd3; imem_ready = 1'b0;
    rw_m = 1'b1; rd_m = 5'd2; rs1_e = 5'd2;
    #1;
    check("rst_outs", {stall_f, stall_d, flush_d, flush_e, fwd_a_e, fwd_b_e}, 0);
    check("rst_regs", {imem_timeout, stall_cnt, flush_cnt}, 0);
    model_reset();
    @(negedge clk);
    quiet();
    rst_n = 1'b1;
  endtask

  initial begin
    int sc0;
    quiet();
    model_reset();
    @(negedge clk);
    do_reset();

    // load-use: lw x5 in EX, add x6,x5,x1 in D
    ld_e = 1; rd_e = 5; rs1_d = 5; rs2_d = 1;
    #1 check("lu_stall", {stall_f, stall_d, flush_e, flush_d}, 4'b1110);
    step();
    ld_e = 0;
    #1 check("lu_clear", {stall_f, stall_d, flush_e, flush_d}, 4'b0000);
    step();

    // forwarding priority
    rw_m = 1; rw_w = 1; rd_m = 7; rd_w = 7; rs1_e = 7;
    #1 check("fwd_mem", fwd_a_e, 2'b10);
    rw_m = 0;
    #1 check("fwd_wb", fwd_a_e, 2'b01);
    rd_w = 0;
    #1 check("fwd_x0", fwd_a_e, 2'b00);
    step();
    quiet();

    // redirect overrides load-use
    ld_e = 1; rd_e = 4; rs2_d = 4; pc_src_e = 1;
    sc0 = m_fc;
    #1 check("redir_lu", {flush_d, flush_e, stall_f, stall_d}, 4'b1100);
    step();
    check("redir_fcnt", flush_cnt, sc0 + 1);
    quiet();

    // three-cycle imem wait
    sc0 = m_sc;
    imem_ready = 0;
    repeat (3) step();
    imem_ready = 1;
    #1 check("wait3_cnt", stall_cnt, sc0 + 3);
    check("wait3_run", stall_f, 1'b0);
    step();

    // redirect during a wait: the returned instruction is discarded
    imem_ready = 0; step();
    pc_src_e = 1; step();
    pc_src_e = 0; imem_ready = 1;
    #1 check("redir_discard", {stall_f, flush_d}, 2'b11);
    step();
    #1 check("redir_done", {stall_f, flush_d}, 2'b00);
    step();

    // timeout boundary: set exactly after the fifteenth not-ready cycle
    imem_ready = 0;
    repeat (14) step();
    check("to_14", imem_timeout, 1'b0);
    step();
    check("to_15", imem_timeout, 1'b1);
    imem_ready = 1; step(); step();
    check("to_sticky", imem_timeout, 1'b1);
    do_reset();
    check("to_cleared", imem_timeout, 1'b0);

    // random traffic, long enough to saturate the narrow counters
    for (int i = 0; i < 600; i++) begin
      rs1_d = 5'($urandom_range(0, 3)); rs2_d = 5'($urandom_range(0, 3));
      rs1_e = 5'($urandom_range(0, 3)); rs2_e = 5'($urandom_range(0, 3));
      rd_e  = 5'($urandom_range(0, 3)); rd_m  = 5'($urandom_range(0, 3));
      rd_w  = 5'($urandom_range(0, 3));
      ld_e = 1'($urandom_range(0, 1)); rw_m = 1'($urandom_range(0, 1));
      rw_w = 1'($urandom_range(0, 1));
      pc_src_e   = ($urandom_range(0, 7) == 0);
      imem_ready = (i % 100 > 70) ? 1'b0 : ($urandom_range(0, 3) != 0);
      step();
    end
    check("sat_stall", stall_cnt, cmax);
    check("sat_flush", flush_cnt, cmax);

    // reset in the middle of a redirect drops it
    quiet();
    imem_ready = 0; pc_src_e = 1; step();
    do_reset();
    #1 check("post_rst_run", {stall_f, flush_d}, 2'b00);
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
